// File: rtl/alu_regfile.sv
// Register file with two combinational read ports plus an independent 4-op ALU.
// Optional macro RF_BYPASS_EN forwards same-cycle write data to matching read ports.
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        alu_op,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] alu_s;

  // Next-state of the register file: single write port, gated by reg_write.
  always_comb begin
    regs_d = regs_q;
    if (reg_write) begin
      regs_d[write_reg] = write_data;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register storage; synchronous reset wins over a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    rd1_s = regs_q[read_reg1];
    rd2_s = regs_q[read_reg2];
`ifdef RF_BYPASS_EN
    if (reg_write && !rst && (read_reg1 == write_reg)) begin
      rd1_s = write_data;
    end else begin
      rd1_s = regs_q[read_reg1];
    end
    if (reg_write && !rst && (read_reg2 == write_reg)) begin
      rd2_s = write_data;
    end else begin
      rd2_s = regs_q[read_reg2];
    end
`endif
  end

  assign read_data1 = rd1_s;
  assign read_data2 = rd2_s;

  // ALU is purely combinational; add/sub wrap and drop carry/borrow.
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (alu_op)
      2'b00:   alu_s = a + b;
      2'b01:   alu_s = a - b;
      2'b10:   alu_s = a & b;
      2'b11:   alu_s = a | b;
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  assign result = alu_s;
  assign zero   = (alu_s == {DATA_W{1'b0}});

endmodule

// File: tb/tb_alu_regfile.sv
// Directed self-checking bench for alu_regfile (DATA_W=8, ADDR_W=3).
module tb_alu_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       reg_write;
  logic [2:0] write_reg;
  logic [7:0] write_data;
  logic [2:0] read_reg1;
  logic [2:0] read_reg2;
  logic [7:0] read_data1;
  logic [7:0] read_data2;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] alu_op;
  logic [7:0] result;
  logic       zero;

  int pass_cnt = 0;
  int total_cnt = 0;

  alu_regfile #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .a(a), .b(b),
    .alu_op(alu_op), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_one(input logic [2:0] addr, input logic [7:0] data);
    reg_write  = 1'b1;
    write_reg  = addr;
    write_data = data;
    tick();
    reg_write  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reg_write = 1'b0; write_reg = 3'd0; write_data = 8'h00;
    read_reg1 = 3'd0; read_reg2 = 3'd0; a = 8'h00; b = 8'h00; alu_op = 2'b00;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_reg1 = i[2:0];
      read_reg2 = 3'(7 - i);
      #1;
      total_cnt++;
      if (read_data1 !== 8'h00 || read_data2 !== 8'h00)
        $display("FAIL reset_state reg%0d: got rd1=%h rd2=%h, want 00/00", i, read_data1, read_data2);
      else pass_cnt++;
    end
  endtask

  task automatic test_regfile_write();
    logic [7:0] exp;
    write_one(3'd2, 8'hAA);
    write_one(3'd0, 8'h11);
    write_reg = 3'd4; write_data = 8'h99;  // reg_write low: must be ignored
    tick();
    for (int i = 0; i < 8; i++) begin
      read_reg1 = i[2:0];
      #1;
      exp = (i == 2) ? 8'hAA : (i == 0) ? 8'h11 : 8'h00;
      total_cnt++;
      if (read_data1 !== exp)
        $display("FAIL write_read reg%0d: got %h, want %h", i, read_data1, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_dual_read();
    read_reg1 = 3'd2; read_reg2 = 3'd2;
    #1;
    total_cnt++;
    if (read_data1 !== 8'hAA || read_data2 !== 8'hAA)
      $display("FAIL dual_read_same: got %h/%h, want aa/aa", read_data1, read_data2);
    else pass_cnt++;
    read_reg1 = 3'd0; read_reg2 = 3'd2;
    #1;
    total_cnt++;
    if (read_data1 !== 8'h11 || read_data2 !== 8'hAA)
      $display("FAIL dual_read_indep: got %h/%h, want 11/aa", read_data1, read_data2);
    else pass_cnt++;
  endtask

  task automatic test_alu();
    logic [7:0] va [8]  = '{8'h05, 8'hFF, 8'h0F, 8'h00, 8'hCC, 8'hCC, 8'h00, 8'h80};
    logic [7:0] vb [8]  = '{8'h0A, 8'h01, 8'h0F, 8'h01, 8'hAA, 8'hAA, 8'h00, 8'h7F};
    logic [1:0] vop [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10};
    logic [7:0] vr [8]  = '{8'h0F, 8'h00, 8'h00, 8'hFF, 8'h88, 8'hEE, 8'h00, 8'h00};
    logic       vz [8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i]; alu_op = vop[i];
      #1;
      total_cnt++;
      if (result !== vr[i] || zero !== vz[i])
        $display("FAIL alu_vec%0d: got result=%h zero=%b, want %h/%b", i, result, zero, vr[i], vz[i]);
      else pass_cnt++;
    end
    // ALU must ignore reset and register file traffic
    rst = 1'b1; reg_write = 1'b1; a = 8'h30; b = 8'h12; alu_op = 2'b01;
    @(posedge clk);
    #1;
    total_cnt++;
    if (result !== 8'h1E || zero !== 1'b0)
      $display("FAIL alu_during_rst: got %h/%b, want 1e/0", result, zero);
    else pass_cnt++;
    rst = 1'b0; reg_write = 1'b0;
  endtask

  task automatic test_rst_priority();
    for (int i = 0; i < 8; i++) write_one(i[2:0], 8'(8'h21 + 8'(i * 17)));
    read_reg1 = 3'd7;
    #1;
    total_cnt++;
    if (read_data1 !== 8'h98)
      $display("FAIL fill_check reg7: got %h, want 98", read_data1);
    else pass_cnt++;
    rst = 1'b1; reg_write = 1'b1; write_reg = 3'd3; write_data = 8'h77;
    tick();
    rst = 1'b0; reg_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      read_reg1 = i[2:0]; read_reg2 = i[2:0];
      #1;
      total_cnt++;
      if (read_data1 !== 8'h00 || read_data2 !== 8'h00)
        $display("FAIL rst_priority reg%0d: got %h/%h, want 00/00", i, read_data1, read_data2);
      else pass_cnt++;
    end
    tick();
    read_reg1 = 3'd3;
    #1;
    total_cnt++;
    if (read_data1 !== 8'h00)
      $display("FAIL post_rst_hold reg3: got %h, want 00", read_data1);
    else pass_cnt++;
  endtask

  task automatic test_read_during_write();
    logic [7:0] exp_pre;
    write_one(3'd5, 8'h5A);
    reg_write = 1'b1; write_reg = 3'd5; write_data = 8'h3C;
    read_reg2 = 3'd5; read_reg1 = 3'd2;
    #1;
`ifdef RF_BYPASS_EN
    exp_pre = 8'h3C;
`else
    exp_pre = 8'h5A;
`endif
    total_cnt++;
    if (read_data2 !== exp_pre)
      $display("FAIL rdw_before_edge: got %h, want %h", read_data2, exp_pre);
    else pass_cnt++;
    total_cnt++;
    if (read_data1 !== 8'h00)
      $display("FAIL rdw_other_port: got %h, want 00", read_data1);
    else pass_cnt++;
    tick();
    reg_write = 1'b0;
    #1;
    total_cnt++;
    if (read_data2 !== 8'h3C)
      $display("FAIL rdw_after_edge: got %h, want 3c", read_data2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_regfile_write();
    test_dual_read();
    test_alu();
    test_rst_priority();
    test_read_during_write();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
